// File: rtl/panda_dmem_arbiter_if.sv
// panda_dmem_arbiter_if: req/gnt/rvalid data-memory port shared by requesters and the memory side
//   req, addr[31:0], we[3:0], wdata[31:0] : request phase, driven by the master
//   gnt, rvalid, rdata[31:0]              : grant and response phase, driven by the slave
interface panda_dmem_arbiter_if;
  logic        req;
  logic [31:0] addr;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  modport master (output req, addr, we, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/panda_dmem_arbiter.sv
// panda_dmem_arbiter: shares one data-memory port between the core LSU (m0) and a debug/DMA master (m1)
//   clk_i, rst_i : clock, asynchronous active-high reset
//   m0, m1       : requester ports (slave side of the handshake)
//   mem          : memory port (master side of the handshake)
//   err_o        : sticky, memory response seen with no transaction outstanding
module panda_dmem_arbiter #(
  parameter bit PRIO_RR   = 1'b1,
  parameter int MAX_OUTST = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  panda_dmem_arbiter_if.slave         m0,
  panda_dmem_arbiter_if.slave         m1,
  panda_dmem_arbiter_if.master        mem,
  output logic                        err_o
);
  localparam int PW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);
  logic [MAX_OUTST-1:0] own_q;
  logic [PW-1:0]        wr_q, rd_q;
  logic [CW-1:0]        cnt_q;
  logic                 lock_q, sel_q, rr_q;
  logic                 sel, both, empty, head, pop, push, room, req;
  always_comb begin
    both  = m0.req & m1.req;
    empty = cnt_q == '0;
    head  = own_q[rd_q];
    pop   = ~rst_i & mem.rvalid & ~empty;
    // a response in the same cycle frees its slot for a new grant
    room  = (cnt_q < CW'(MAX_OUTST)) | pop;
    sel   = lock_q ? sel_q : both ? (PRIO_RR & rr_q) : m1.req;
    req   = ~rst_i & (lock_q | ((m0.req | m1.req) & room));
    push  = req & mem.gnt;
    mem.req    = req;
    mem.addr   = req ? (sel ? m1.addr  : m0.addr)  : '0;
    mem.we     = req ? (sel ? m1.we    : m0.we)    : '0;
    mem.wdata  = req ? (sel ? m1.wdata : m0.wdata) : '0;
    m0.gnt     = push & ~sel;
    m1.gnt     = push & sel;
    m0.rvalid  = pop & ~head;
    m1.rvalid  = pop & head;
    m0.rdata   = m0.rvalid ? mem.rdata : '0;
    m1.rdata   = m1.rvalid ? mem.rdata : '0;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      own_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      lock_q <= 1'b0;
      sel_q  <= 1'b0;
      rr_q   <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      // a stalled request keeps its selection until the memory accepts it
      lock_q <= req & ~mem.gnt;
      sel_q  <= sel;
      if (push & both) rr_q <= ~sel;
      if (push) begin
        own_q[wr_q] <= sel;
        wr_q        <= wr_q == PW'(MAX_OUTST - 1) ? '0 : wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q == PW'(MAX_OUTST - 1) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      err_o <= err_o | (mem.rvalid & empty);
    end
endmodule

// File: tb/tb_panda_dmem_arbiter.sv
// tb_panda_dmem_arbiter: directed checks of fixed priority, round-robin, lock, backpressure and error handling
module tb_panda_dmem_arbiter;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic err_a, err_b;
  int   checks = 0;
  int   errors = 0;
  panda_dmem_arbiter_if a0(), a1(), am(), b0(), b1(), bm();
  panda_dmem_arbiter #(.PRIO_RR(1'b0), .MAX_OUTST(2)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .m0(a0), .m1(a1), .mem(am), .err_o(err_a)
  );
  panda_dmem_arbiter #(.PRIO_RR(1'b1), .MAX_OUTST(1)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .m0(b0), .m1(b1), .mem(bm), .err_o(err_b)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    {a0.req, a0.addr, a0.we, a0.wdata} = '0;
    {a1.req, a1.addr, a1.we, a1.wdata} = '0;
    {am.gnt, am.rvalid, am.rdata} = '0;
    {b0.req, b0.addr, b0.we, b0.wdata} = '0;
    {b1.req, b1.addr, b1.we, b1.wdata} = '0;
    {bm.gnt, bm.rvalid, bm.rdata} = '0;
    a0.req = 1'b1; a0.addr = 32'h100; am.gnt = 1'b1; am.rvalid = 1'b1;
    #1;
    check("rst_mem_req", am.req, 0);
    check("rst_gnt", a0.gnt, 0);
    check("rst_rvalid", a0.rvalid, 0);
    check("rst_addr", am.addr, 0);
    check("rst_err", err_a, 0);
    a0.req = 1'b0; am.rvalid = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    a0.addr = 32'h1000; a0.req = 1'b1;
    a1.addr = 32'h2000; a1.we = 4'hf; a1.wdata = 32'h55; a1.req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      am.rvalid = i > 0; am.rdata = 32'hA0 + i;
      #1;
      check("fp_gnt0", a0.gnt, 1);
      check("fp_gnt1", a1.gnt, 0);
      check("fp_addr", am.addr, 32'h1000);
      check("fp_we", am.we, 0);
      check("fp_rv0", a0.rvalid, i > 0);
      check("fp_rdata0", a0.rdata, i > 0 ? 32'hA0 + i : 0);
      check("fp_rv1", a1.rvalid, 0);
      tick();
    end
    a0.req = 1'b0; a1.req = 1'b0; am.rdata = 32'hA3;
    #1;
    check("fp_drain_rv0", a0.rvalid, 1);
    check("fp_drain_rdata", a0.rdata, 32'hA3);
    check("idle_mem_req", am.req, 0);
    check("idle_addr", am.addr, 0);
    tick();
    am.rvalid = 1'b0; am.gnt = 1'b0; a1.req = 1'b1;
    #1;
    check("lk_req", am.req, 1);
    check("lk_addr1", am.addr, 32'h2000);
    check("lk_wdata", am.wdata, 32'h55);
    check("lk_we", am.we, 4'hf);
    tick();
    a0.req = 1'b1;
    #1;
    check("lk_addr2", am.addr, 32'h2000);
    check("lk_gnt0_2", a0.gnt, 0);
    tick();
    #1;
    check("lk_addr3", am.addr, 32'h2000);
    tick();
    am.gnt = 1'b1;
    #1;
    check("lk_gnt1", a1.gnt, 1);
    check("lk_gnt0", a0.gnt, 0);
    tick();
    a1.req = 1'b0; a1.we = 4'h0;
    #1;
    check("lk_next_gnt0", a0.gnt, 1);
    check("lk_next_addr", am.addr, 32'h1000);
    tick();
    a0.req = 1'b0; am.rvalid = 1'b1; am.rdata = 32'h11;
    #1;
    check("lk_rsp_rv1", a1.rvalid, 1);
    check("lk_rsp_rv0", a0.rvalid, 0);
    check("lk_rsp_rdata1", a1.rdata, 32'h11);
    tick();
    am.rdata = 32'h22;
    #1;
    check("lk_rsp2_rv0", a0.rvalid, 1);
    check("lk_rsp2_rv1", a1.rvalid, 0);
    check("lk_rsp2_rdata0", a0.rdata, 32'h22);
    tick();
    am.rvalid = 1'b0; a0.req = 1'b1; a0.addr = 32'h3000;
    #1;
    check("bp_gnt_a", a0.gnt, 1);
    tick();
    a0.addr = 32'h3004;
    #1;
    check("bp_gnt_b", a0.gnt, 1);
    tick();
    a0.addr = 32'h3008;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("bp_full_req", am.req, 0);
      check("bp_full_gnt", a0.gnt, 0);
      tick();
    end
    am.rvalid = 1'b1; am.rdata = 32'h33;
    #1;
    check("bp_pop_req", am.req, 1);
    check("bp_pop_gnt", a0.gnt, 1);
    check("bp_pop_addr", am.addr, 32'h3008);
    check("bp_pop_rdata", a0.rdata, 32'h33);
    tick();
    a0.req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      am.rdata = 32'h44 + i;
      #1;
      check("bp_drain_rv0", a0.rvalid, 1);
      check("bp_drain_rdata", a0.rdata, 32'h44 + i);
      tick();
    end
    am.rdata = 32'hDEADBEEF;
    #1;
    check("sp_rv0", a0.rvalid, 0);
    check("sp_rv1", a1.rvalid, 0);
    check("sp_rdata0", a0.rdata, 0);
    check("sp_err_before", err_a, 0);
    tick();
    am.rvalid = 1'b0;
    #1;
    check("sp_err", err_a, 1);
    tick();
    tick();
    check("sp_err_sticky", err_a, 1);
    a0.req = 1'b1; a0.addr = 32'h4000;
    #1;
    check("rm_gnt0", a0.gnt, 1);
    tick();
    a0.req = 1'b0; rst_i = 1'b1;
    #1;
    check("rm_err_clear", err_a, 0);
    tick();
    rst_i = 1'b0;
    #1;
    am.rvalid = 1'b1; am.rdata = 32'h77;
    #1;
    check("rm_rv0", a0.rvalid, 0);
    check("rm_rv1", a1.rvalid, 0);
    tick();
    am.rvalid = 1'b0;
    #1;
    check("rm_err", err_a, 1);
    b0.req = 1'b1; b0.addr = 32'h5000;
    b1.req = 1'b1; b1.addr = 32'h6000;
    bm.gnt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bm.rvalid = i > 0; bm.rdata = 32'hB00 + i;
      #1;
      check("rr_gnt0", b0.gnt, i % 2 == 0);
      check("rr_gnt1", b1.gnt, i % 2 == 1);
      check("rr_addr", bm.addr, i % 2 ? 32'h6000 : 32'h5000);
      check("rr_rv0", b0.rvalid, i > 0 && (i - 1) % 2 == 0);
      check("rr_rv1", b1.rvalid, i > 0 && (i - 1) % 2 == 1);
      check("rr_rdata0", b0.rdata, i > 0 && (i - 1) % 2 == 0 ? 32'hB00 + i : 0);
      check("rr_rdata1", b1.rdata, i > 0 && (i - 1) % 2 == 1 ? 32'hB00 + i : 0);
      tick();
    end
    b0.req = 1'b0; b1.req = 1'b0; bm.rdata = 32'hBFF;
    #1;
    check("rr_drain_rv1", b1.rvalid, 1);
    check("rr_drain_rdata1", b1.rdata, 32'hBFF);
    check("rr_drain_rv0", b0.rvalid, 0);
    tick();
    bm.rvalid = 1'b0;
    #1;
    check("rr_err", err_b, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
